// File: rtl/my_arbiter8way16.sv
// Round-robin arbiter sharing one 8-way 16-bit mux among eight requesters.
// The granted word lands in a single registered slot drained by valid/ready.
// The shared mux lives in this file too so the block stays self-contained.

module my_mux8way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);

  // Plain 8:1 word select, index order a..h.
  always_comb begin
    out = a;
    unique case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
    endcase
  end

endmodule

module my_arbiter8way16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  output logic [7:0]  ack,
  output logic [15:0] out,
  output logic [2:0]  out_sel,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [2:0]  ptr_q;
  logic [15:0] out_q;
  logic [2:0]  out_sel_q;
  logic        out_valid_q;

  logic [2:0]  gnt;
  logic        any;
  logic        free;
  logic        accept;
  logic [15:0] mux_out;

  assign any    = |req;
  assign free   = !out_valid_q || out_ready;
  assign accept = rst_n && free && any;

  // Rotating priority search: scan ptr+7 down to ptr so the lowest offset wins.
  always_comb begin
    logic [2:0] idx;
    gnt = 3'd0;
    idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr_q + 3'(k);
      if (req[idx]) gnt = idx;
    end
  end

  // One-hot acknowledge of the winner, suppressed in reset and under backpressure.
  always_comb begin
    ack = 8'h00;
    if (accept) ack = 8'h01 << gnt;
  end

  my_mux8way16 u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .f   (f),
    .g   (g),
    .h   (h),
    .sel (gnt),
    .out (mux_out)
  );

  // Output slot and priority pointer; a load and a drain on the same edge keep valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= 3'd0;
      out_q       <= 16'h0000;
      out_sel_q   <= 3'd0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      ptr_q       <= gnt + 3'd1;
      out_q       <= mux_out;
      out_sel_q   <= gnt;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out       = out_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
